// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory: FSM encoding, NOP word and defaults.
// The optional bounds/alignment check is enabled by defining IMEM_BOUNDS_CHECK_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } imem_state_e;

  localparam int unsigned DataWidthDefault  = 32;
  localparam int unsigned DepthDefault      = 256;
  localparam int unsigned WaitStatesDefault = 1;

  // NOP is all-zero; replicate this bit to any instruction width.
  localparam logic NopBit = 1'b0;

  // A fetch faults when the byte address is misaligned or beyond the array.
  function automatic logic pc_fault(input logic [31:0] pc, input int unsigned depth);
    return (pc[1:0] != 2'b00) || (pc >= 32'(depth * 4));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one combinational read port.
// Contents are never reset.
module imem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned AddrWidth = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrWidth-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AddrWidth-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_memory.sv
// Instruction fetch memory: valid/ready request, WAIT_STATES latency, held response.
// Define IMEM_BOUNDS_CHECK_EN to fault misaligned or out-of-range fetches.
module instr_fetch_memory
  import imem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DataWidthDefault,
  parameter int unsigned DEPTH       = DepthDefault,
  parameter int unsigned WAIT_STATES = WaitStatesDefault,
  localparam int unsigned AddrWidth  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [31:0]           programCounter,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  fault,
  input  logic                  loadEnable,
  input  logic [AddrWidth-1:0]  loadAddress,
  input  logic [DATA_WIDTH-1:0] loadData
);

  imem_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] req_word;
  logic                  req_fault;

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (loadEnable),
    .waddr_i (loadAddress),
    .wdata_i (loadData),
    .raddr_i (programCounter[AddrWidth+1:2]),
    .rdata_o (rd_data)
  );

`ifdef IMEM_BOUNDS_CHECK_EN
  assign req_fault = pc_fault(programCounter, DEPTH);
  assign req_word  = req_fault ? {DATA_WIDTH{NopBit}} : rd_data;
`else
  // Address wraps modulo DEPTH and byte offset is ignored.
  logic unused_pc;
  assign unused_pc = ^{programCounter[31:AddrWidth+2], programCounter[1:0]};
  assign req_fault = 1'b0;
  assign req_word  = rd_data;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    reqReady  = 1'b0;
    respValid = 1'b0;
    case (state_q)
      StIdle: begin
        reqReady = 1'b1;
        if (reqValid) begin
          // Sampling here gives read-before-write against a same-edge load.
          instr_d = req_word;
          fault_d = req_fault;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        respValid = 1'b1;
        if (respReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      instr_q <= {DATA_WIDTH{NopBit}};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign instruction = respValid ? instr_q : {DATA_WIDTH{NopBit}};
  assign fault       = respValid & fault_q;

endmodule

// File: tb/tb_instr_fetch_memory.sv
// Directed bench: three instances (WAIT_STATES 1, 0, 3) share clock, reset and load bus.
// Expected values for out-of-range fetches depend on IMEM_BOUNDS_CHECK_EN.
module tb_instr_fetch_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] pc;
  logic        resp_ready;
  logic        rv_w1, rv_w0, rv_w3;

  logic        rq_w1, rs_w1, f_w1;
  logic        rq_w0, rs_w0, f_w0;
  logic        rq_w3, rs_w3, f_w3;
  logic [31:0] in_w1, in_w0, in_w3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_memory #(.DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset), .reqValid(rv_w1), .reqReady(rq_w1), .programCounter(pc),
    .respValid(rs_w1), .respReady(resp_ready), .instruction(in_w1), .fault(f_w1),
    .loadEnable(load_en), .loadAddress(load_addr), .loadData(load_data)
  );

  instr_fetch_memory #(.DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset), .reqValid(rv_w0), .reqReady(rq_w0), .programCounter(pc),
    .respValid(rs_w0), .respReady(resp_ready), .instruction(in_w0), .fault(f_w0),
    .loadEnable(load_en), .loadAddress(load_addr), .loadData(load_data)
  );

  instr_fetch_memory #(.DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset), .reqValid(rv_w3), .reqReady(rq_w3), .programCounter(pc),
    .respValid(rs_w3), .respReady(resp_ready), .instruction(in_w3), .fault(f_w3),
    .loadEnable(load_en), .loadAddress(load_addr), .loadData(load_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = idx;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  logic [31:0] exp_oor_word;
  logic        exp_oor_fault;

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; pc = '0;
    resp_ready = 1'b0; rv_w1 = 1'b0; rv_w0 = 1'b0; rv_w3 = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk_bit("rst_reqReady_w1", rq_w1, 1'b1);
    chk_bit("rst_respValid_w1", rs_w1, 1'b0);
    chk_word("rst_instr_w1", in_w1, 32'h0);
    chk_bit("rst_fault_w1", f_w1, 1'b0);
    chk_bit("rst_reqReady_w3", rq_w3, 1'b1);

    load(8'd0, 32'hA0A0_A0A0);
    load(8'd1, 32'h1111_1111);
    load(8'd3, 32'h8C01_0004);

    // WAIT_STATES=1: accept at T, respValid at T+2
    pc = 32'h0000_000C; rv_w1 = 1'b1;
    step();
    rv_w1 = 1'b0;
    chk_bit("w1_t1_respValid", rs_w1, 1'b0);
    chk_bit("w1_t1_reqReady", rq_w1, 1'b0);
    chk_word("w1_t1_instr_zero", in_w1, 32'h0);
    step();
    chk_bit("w1_t2_respValid", rs_w1, 1'b1);
    chk_word("w1_t2_instr", in_w1, 32'h8C01_0004);
    chk_bit("w1_t2_fault", f_w1, 1'b0);
    handshake();
    chk_bit("w1_idle_reqReady", rq_w1, 1'b1);
    chk_bit("w1_idle_respValid", rs_w1, 1'b0);

    // WAIT_STATES=0 with respReady held low for 5 cycles
    pc = 32'h0000_000C; rv_w0 = 1'b1;
    step();
    rv_w0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_bit("w0_hold_respValid", rs_w0, 1'b1);
      chk_word("w0_hold_instr", in_w0, 32'h8C01_0004);
      chk_bit("w0_hold_reqReady", rq_w0, 1'b0);
      step();
    end
    // A request during the response handshake must be ignored
    rv_w0 = 1'b1; resp_ready = 1'b1;
    chk_bit("w0_hs_reqReady", rq_w0, 1'b0);
    step();
    rv_w0 = 1'b0; resp_ready = 1'b0;
    chk_bit("w0_after_hs_reqReady", rq_w0, 1'b1);
    chk_bit("w0_after_hs_respValid", rs_w0, 1'b0);
    step();
    chk_bit("w0_no_extra_resp", rs_w0, 1'b0);

    // Same-cycle load and fetch of word 1: old value returned
    pc = 32'h0000_0004; rv_w1 = 1'b1;
    load_en = 1'b1; load_addr = 8'd1; load_data = 32'h2222_2222;
    step();
    rv_w1 = 1'b0; load_en = 1'b0;
    step();
    chk_word("rbw_old_word", in_w1, 32'h1111_1111);
    handshake();
    rv_w1 = 1'b1;
    step();
    rv_w1 = 1'b0;
    step();
    chk_word("rbw_refetch", in_w1, 32'h2222_2222);
    handshake();

`ifdef IMEM_BOUNDS_CHECK_EN
    exp_oor_word = 32'h0;
    exp_oor_fault = 1'b1;
`else
    exp_oor_word = 32'hA0A0_A0A0;
    exp_oor_fault = 1'b0;
`endif
    pc = 32'h0000_0402; rv_w1 = 1'b1;
    step();
    rv_w1 = 1'b0;
    step();
    chk_bit("pc402_respValid", rs_w1, 1'b1);
    chk_word("pc402_instr", in_w1, exp_oor_word);
    chk_bit("pc402_fault", f_w1, exp_oor_fault);
    handshake();
    pc = 32'h0000_0400; rv_w1 = 1'b1;
    step();
    rv_w1 = 1'b0;
    step();
    chk_word("pc400_instr", in_w1, exp_oor_word);
    chk_bit("pc400_fault", f_w1, exp_oor_fault);
    handshake();

    // WAIT_STATES=3: a load after acceptance must not change the response
    pc = 32'h0000_000C; rv_w3 = 1'b1;
    step();
    rv_w3 = 1'b0;
    load(8'd3, 32'h5555_5555);
    chk_bit("w3_t2_respValid", rs_w3, 1'b0);
    step();
    chk_bit("w3_t3_respValid", rs_w3, 1'b0);
    step();
    chk_bit("w3_t4_respValid", rs_w3, 1'b1);
    chk_word("w3_inflight_instr", in_w3, 32'h8C01_0004);
    handshake();

    // Reset mid-WAIT, with a load on the reset edge
    pc = 32'h0000_0004; rv_w3 = 1'b1;
    step();
    rv_w3 = 1'b0;
    chk_bit("w3_wait_respValid", rs_w3, 1'b0);
    reset = 1'b1;
    load(8'd2, 32'h6666_6666);
    reset = 1'b0;
    chk_bit("w3_rst_reqReady", rq_w3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_bit("w3_rst_no_resp", rs_w3, 1'b0);
      step();
    end
    pc = 32'h0000_000C; rv_w3 = 1'b1;
    step();
    rv_w3 = 1'b0;
    step(); step(); step();
    chk_word("w3_keep_word3", in_w3, 32'h5555_5555);
    handshake();
    pc = 32'h0000_0008; rv_w3 = 1'b1;
    step();
    rv_w3 = 1'b0;
    step(); step(); step();
    chk_word("w3_load_in_reset", in_w3, 32'h6666_6666);
    handshake();
    pc = 32'h0000_0004; rv_w1 = 1'b1;
    step();
    rv_w1 = 1'b0;
    step();
    chk_word("w1_keep_word1", in_w1, 32'h2222_2222);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
